// File: rtl/id_stage_pkg.sv
// Shared decode types, opcode map and helper functions for the RV32 ID stage.
package id_stage_pkg;

  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned REG_IDX_W  = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2
  } wb_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef struct packed {
    alu_op_e aluop;
    logic    rf_en;
    logic    dm_en;
    logic    opr_b_sel;
    wb_sel_e wb_sel;
  } ctrl_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  illegal;
  } dec_t;

  // Register index exists in a file of reg_count entries (32 or 16).
  function automatic logic reg_in_range_f(input logic [4:0] idx, input int unsigned reg_count);
    return (reg_count == 32'd32) || (idx < 5'(reg_count));
  endfunction

  function automatic logic uses_rs1_f(input logic [6:0] opcode);
    return !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
  endfunction

  function automatic logic uses_rs2_f(input logic [6:0] opcode);
    return (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  endfunction

  function automatic alu_op_e alu_op_f(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [INST_WIDTH-1:0] gen_imm_f(input logic [INST_WIDTH-1:0] inst);
    logic [INST_WIDTH-1:0] imm;
    imm = '0;
    case (inst[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm = {inst[31:12], 12'b0};
      OPC_JAL:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:    imm = '0;
    endcase
    return imm;
  endfunction

  // Control decode; unknown opcodes come back all-zero with illegal set.
  function automatic dec_t ctrl_unit_f(input logic [6:0] opcode, input logic [2:0] funct3,
                                       input logic funct7_5);
    dec_t d;
    d = '0;
    case (opcode)
      OPC_OP: begin
        d.ctrl.aluop = alu_op_f(funct3, funct7_5);
        d.ctrl.rf_en = 1'b1;
      end
      OPC_OPIMM: begin
        d.ctrl.aluop     = alu_op_f(funct3, funct7_5 & (funct3 == 3'b101));
        d.ctrl.rf_en     = 1'b1;
        d.ctrl.opr_b_sel = 1'b1;
      end
      OPC_LOAD: begin
        d.ctrl.rf_en     = 1'b1;
        d.ctrl.opr_b_sel = 1'b1;
        d.ctrl.wb_sel    = WB_MEM;
      end
      OPC_STORE: begin
        d.ctrl.dm_en     = 1'b1;
        d.ctrl.opr_b_sel = 1'b1;
      end
      OPC_BRANCH: d.ctrl.aluop = ALU_SUB;
      OPC_LUI: begin
        d.ctrl.aluop     = ALU_PASSB;
        d.ctrl.rf_en     = 1'b1;
        d.ctrl.opr_b_sel = 1'b1;
      end
      OPC_AUIPC: begin
        d.ctrl.rf_en     = 1'b1;
        d.ctrl.opr_b_sel = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        d.ctrl.rf_en     = 1'b1;
        d.ctrl.opr_b_sel = 1'b1;
        d.ctrl.wb_sel    = WB_PC;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_stage_hz_rf_bypass.sv
// Register file (32 or 16 entries) with combinational read and same-cycle
// write-through from the writeback port.
module id_stage_hz_rf_bypass
  import id_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  wb_rf_en,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data
);

  localparam int unsigned AW = $clog2(REG_COUNT);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic                  wr_en;

  // Out-of-range destinations are dropped rather than aliased onto low registers.
  assign wr_en = wb_rf_en && (wb_rd != 5'd0) && reg_in_range_f(wb_rd, REG_COUNT);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < int'(REG_COUNT); i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wb_rd[AW-1:0]] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    if ((rs1 != 5'd0) && reg_in_range_f(rs1, REG_COUNT)) rs1_data = regs[rs1[AW-1:0]];
    if (wb_rf_en && (wb_rd == rs1) && (rs1 != 5'd0)) rs1_data = wb_data;
  end

  always_comb begin
    rs2_data = '0;
    if ((rs2 != 5'd0) && reg_in_range_f(rs2, REG_COUNT)) rs2_data = regs[rs2[AW-1:0]];
    if (wb_rf_en && (wb_rd == rs2) && (rs2 != 5'd0)) rs2_data = wb_data;
  end

endmodule

// File: rtl/id_stage_hz.sv
// RV32I/RV32E decode stage with ID/EX pipeline register, load-use bubble
// insertion, flush and a saturating hazard-stall counter.
module id_stage_hz
  import id_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  valid_in,
  input  logic [31:0]           inst_in,
  input  logic [DATA_WIDTH-1:0] pc_in,
  output logic                  ready_out,
  input  logic                  flush_in,
  input  logic                  wb_rf_en,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_opr_a,
  output logic [DATA_WIDTH-1:0] ex_opr_b,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [4:0]            ex_rs1,
  output logic [4:0]            ex_rs2,
  output logic [4:0]            ex_rd,
  output ctrl_t                 ex_ctrl,
  output logic                  ex_illegal,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  logic [6:0]            opcode;
  logic [4:0]            rs1, rs2, rd;
  logic [DATA_WIDTH-1:0] rs1_data, rs2_data;
  dec_t                  dec;
  ctrl_t                 id_ctrl;
  logic                  id_illegal;
  logic                  use1, use2;
  logic                  hazard, load_en;

  assign opcode = inst_in[6:0];
  assign rd     = inst_in[11:7];
  assign rs1    = inst_in[19:15];
  assign rs2    = inst_in[24:20];
  assign dec    = ctrl_unit_f(opcode, inst_in[14:12], inst_in[30]);
  assign use1   = uses_rs1_f(opcode);
  assign use2   = uses_rs2_f(opcode);

  id_stage_hz_rf_bypass #(
    .DATA_WIDTH(DATA_WIDTH),
    .REG_COUNT (REG_COUNT)
  ) u_rf (
    .clk     (clk),
    .arst_n  (arst_n),
    .wb_rf_en(wb_rf_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .rs1     (rs1),
    .rs2     (rs2),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data)
  );

  // Illegal instructions travel down with their side effects disabled.
  always_comb begin
    id_illegal = dec.illegal
               | (use1 & ~reg_in_range_f(rs1, REG_COUNT))
               | (use2 & ~reg_in_range_f(rs2, REG_COUNT))
               | (dec.ctrl.rf_en & ~reg_in_range_f(rd, REG_COUNT));
    id_ctrl = dec.ctrl;
    if (id_illegal) begin
      id_ctrl.rf_en = 1'b0;
      id_ctrl.dm_en = 1'b0;
    end
  end

  assign hazard = valid_in & ex_valid & (ex_ctrl.wb_sel == WB_MEM) & (ex_rd != 5'd0)
                & ((use1 & (rs1 == ex_rd)) | (use2 & (rs2 == ex_rd)));
  assign load_en   = ~ex_valid | ex_ready;
  assign ready_out = flush_in | (load_en & ~hazard);

  // ID/EX register: flush, then bubble, then load, else hold.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_opr_a   <= '0;
      ex_opr_b   <= '0;
      ex_imm     <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_ctrl    <= '0;
      ex_illegal <= 1'b0;
    end else if (flush_in) begin
      ex_valid <= 1'b0;
    end else if (load_en) begin
      if (hazard) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid   <= valid_in;
        ex_pc      <= pc_in;
        ex_opr_a   <= rs1_data;
        ex_opr_b   <= rs2_data;
        ex_imm     <= DATA_WIDTH'(gen_imm_f(inst_in));
        ex_rs1     <= rs1;
        ex_rs2     <= rs2;
        ex_rd      <= rd;
        ex_ctrl    <= id_ctrl;
        ex_illegal <= id_illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt <= '0;
    end else if (hazard && load_en && !flush_in && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_id_stage_hz.sv
// Directed bench for id_stage_hz: an RV32I instance driven from a vector table
// plus hand sequences, and an RV32E instance with a 2-bit stall counter.
module tb_id_stage_hz;
  import id_stage_pkg::*;

  logic        clk;
  logic        arst_n;
  logic        valid_in;
  logic [31:0] inst_in;
  logic [31:0] pc_in;
  logic        flush_in;
  logic        wb_rf_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_ready;

  logic        r0_ready, r0_valid, r0_ill;
  logic [31:0] r0_pc, r0_a, r0_b, r0_imm;
  logic [4:0]  r0_rs1, r0_rs2, r0_rd;
  ctrl_t       r0_ctrl;
  logic [15:0] r0_cnt;

  logic        r1_ready, r1_valid, r1_ill;
  logic [31:0] r1_pc, r1_a, r1_b, r1_imm;
  logic [4:0]  r1_rs1, r1_rs2, r1_rd;
  ctrl_t       r1_ctrl;
  logic [1:0]  r1_cnt;

  int total = 0;
  int bad   = 0;

  id_stage_hz #(.DATA_WIDTH(32), .REG_COUNT(32), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .arst_n(arst_n), .valid_in(valid_in), .inst_in(inst_in), .pc_in(pc_in),
    .ready_out(r0_ready), .flush_in(flush_in), .wb_rf_en(wb_rf_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(r0_valid), .ex_pc(r0_pc),
    .ex_opr_a(r0_a), .ex_opr_b(r0_b), .ex_imm(r0_imm), .ex_rs1(r0_rs1), .ex_rs2(r0_rs2),
    .ex_rd(r0_rd), .ex_ctrl(r0_ctrl), .ex_illegal(r0_ill), .stall_cnt(r0_cnt)
  );

  id_stage_hz #(.DATA_WIDTH(32), .REG_COUNT(16), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .arst_n(arst_n), .valid_in(valid_in), .inst_in(inst_in), .pc_in(pc_in),
    .ready_out(r1_ready), .flush_in(flush_in), .wb_rf_en(wb_rf_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(r1_valid), .ex_pc(r1_pc),
    .ex_opr_a(r1_a), .ex_opr_b(r1_b), .ex_imm(r1_imm), .ex_rs1(r1_rs1), .ex_rs2(r1_rs2),
    .ex_rd(r1_rd), .ex_ctrl(r1_ctrl), .ex_illegal(r1_ill), .stall_cnt(r1_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] I_ADDI_X1_5   = 32'h00500093;
  localparam logic [31:0] I_ADD_X3_X2   = 32'h000101B3;
  localparam logic [31:0] I_LW_X5       = 32'h00002283;
  localparam logic [31:0] I_ADD_X6_X5X5 = 32'h00528333;
  localparam logic [31:0] I_LW_X10      = 32'h00002503;
  localparam logic [31:0] I_LUI_X5      = 32'h123452B7;
  localparam logic [31:0] I_ADDI_X6_1   = 32'h00100313;
  localparam logic [31:0] I_SW_X5       = 32'h00502023;
  localparam logic [31:0] I_BAD_OPC     = 32'h0000007F;
  localparam logic [31:0] I_ADD_X17     = 32'h002088B3;
  localparam logic [31:0] I_ADD_X3_X4   = 32'h000201B3;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
    logic        e_ill;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic valid, input logic [31:0] inst, input logic [31:0] pc,
                              input logic wb_en, input logic [4:0] wrd, input logic [31:0] wdat,
                              input logic e_ready, input logic e_valid, input logic [31:0] e_pc,
                              input logic [31:0] e_a, input logic [31:0] e_b,
                              input logic [31:0] e_imm, input logic [4:0] e_rd,
                              input logic e_ill, input logic [15:0] e_cnt);
    vec_t v;
    v.valid = valid; v.inst = inst; v.pc = pc;
    v.wb_en = wb_en; v.wb_rd = wrd; v.wb_data = wdat;
    v.e_ready = e_ready; v.e_valid = e_valid; v.e_pc = e_pc;
    v.e_a = e_a; v.e_b = e_b; v.e_imm = e_imm; v.e_rd = e_rd;
    v.e_ill = e_ill; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wdat);
    valid_in = v; inst_in = inst; pc_in = pc;
    wb_rf_en = we; wb_rd = wrd; wb_data = wdat;
  endtask

  task automatic pre_ready(input string name, input logic exp);
    #1;
    chk(name, {31'b0, r0_ready}, {31'b0, exp});
  endtask

  initial begin
    // Row: inputs | ready before edge, then ID/EX contents after the edge.
    tbl[0]  = mk(1'b1, I_ADDI_X1_5,   32'h100, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 32'h100, 32'h0, 32'h0, 32'h5, 5'd1, 1'b0, 16'd0);
    tbl[1]  = mk(1'b1, I_ADD_X3_X2,   32'h104, 1'b1, 5'd2, 32'hDEADBEEF,
                 1'b1, 1'b1, 32'h104, 32'hDEADBEEF, 32'h0, 32'h0, 5'd3, 1'b0, 16'd0);
    tbl[2]  = mk(1'b1, I_LW_X5,       32'h108, 1'b1, 5'd5, 32'h55,
                 1'b1, 1'b1, 32'h108, 32'h0, 32'h0, 32'h0, 5'd5, 1'b0, 16'd0);
    tbl[3]  = mk(1'b1, I_ADD_X6_X5X5, 32'h10C, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 32'h108, 32'h0, 32'h0, 32'h0, 5'd5, 1'b0, 16'd1);
    tbl[4]  = mk(1'b1, I_ADD_X6_X5X5, 32'h10C, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 32'h10C, 32'h55, 32'h55, 32'h0, 5'd6, 1'b0, 16'd1);
    tbl[5]  = mk(1'b1, I_LW_X10,      32'h110, 1'b1, 5'd0, 32'hFFFFFFFF,
                 1'b1, 1'b1, 32'h110, 32'h0, 32'h0, 32'h0, 5'd10, 1'b0, 16'd1);
    tbl[6]  = mk(1'b1, I_LUI_X5,      32'h114, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 32'h114, 32'h0, 32'h0, 32'h12345000, 5'd5, 1'b0, 16'd1);
    tbl[7]  = mk(1'b1, I_LW_X5,       32'h118, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 32'h118, 32'h0, 32'h0, 32'h0, 5'd5, 1'b0, 16'd1);
    tbl[8]  = mk(1'b1, I_ADDI_X6_1,   32'h11C, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 32'h11C, 32'h0, 32'h0, 32'h1, 5'd6, 1'b0, 16'd1);
    tbl[9]  = mk(1'b1, I_LW_X5,       32'h120, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 32'h120, 32'h0, 32'h0, 32'h0, 5'd5, 1'b0, 16'd1);
    tbl[10] = mk(1'b1, I_SW_X5,       32'h124, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 32'h120, 32'h0, 32'h0, 32'h0, 5'd5, 1'b0, 16'd2);
    tbl[11] = mk(1'b1, I_SW_X5,       32'h124, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 32'h124, 32'h0, 32'h55, 32'h0, 5'd0, 1'b0, 16'd2);
    tbl[12] = mk(1'b1, I_BAD_OPC,     32'h128, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 32'h128, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 16'd2);
    tbl[13] = mk(1'b0, 32'h0,         32'h12C, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 32'h12C, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 16'd2);
    tbl[14] = mk(1'b1, I_LW_X5,       32'h130, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 32'h130, 32'h0, 32'h0, 32'h0, 5'd5, 1'b0, 16'd2);
    tbl[15] = mk(1'b0, I_ADD_X6_X5X5, 32'h134, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 32'h134, 32'h55, 32'h55, 32'h0, 5'd6, 1'b0, 16'd2);

    arst_n = 1'b0; flush_in = 1'b0; ex_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, r0_valid}, 32'h0);
    chk("rst_pc", r0_pc, 32'h0);
    chk("rst_a", r0_a, 32'h0);
    chk("rst_b", r0_b, 32'h0);
    chk("rst_imm", r0_imm, 32'h0);
    chk("rst_idx", {17'b0, r0_rs1, r0_rs2, r0_rd}, 32'h0);
    chk("rst_ctrl", {23'b0, r0_ctrl}, 32'h0);
    chk("rst_ill", {31'b0, r0_ill}, 32'h0);
    chk("rst_cnt", {16'b0, r0_cnt}, 32'h0);
    chk("rst_ready", {31'b0, r0_ready}, 32'h1);
    arst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].valid, tbl[i].inst, tbl[i].pc, tbl[i].wb_en, tbl[i].wb_rd, tbl[i].wb_data);
      pre_ready($sformatf("v%0d_ready", i), tbl[i].e_ready);
      tick();
      chk($sformatf("v%0d_valid", i), {31'b0, r0_valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("v%0d_pc", i), r0_pc, tbl[i].e_pc);
      chk($sformatf("v%0d_a", i), r0_a, tbl[i].e_a);
      chk($sformatf("v%0d_b", i), r0_b, tbl[i].e_b);
      chk($sformatf("v%0d_imm", i), r0_imm, tbl[i].e_imm);
      chk($sformatf("v%0d_rd", i), {27'b0, r0_rd}, {27'b0, tbl[i].e_rd});
      chk($sformatf("v%0d_ill", i), {31'b0, r0_ill}, {31'b0, tbl[i].e_ill});
      chk($sformatf("v%0d_cnt", i), {16'b0, r0_cnt}, {16'b0, tbl[i].e_cnt});
    end

    // EX back-pressure holds ID/EX and blocks IF; flush still kills it.
    drive(1'b1, I_ADDI_X1_5, 32'h200, 1'b0, 5'd0, 32'h0);
    tick();
    chk("hold_load_valid", {31'b0, r0_valid}, 32'h1);
    ex_ready = 1'b0;
    drive(1'b1, I_ADD_X3_X2, 32'h204, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      pre_ready($sformatf("hold%0d_ready", k), 1'b0);
      tick();
      chk($sformatf("hold%0d_valid", k), {31'b0, r0_valid}, 32'h1);
      chk($sformatf("hold%0d_pc", k), r0_pc, 32'h200);
      chk($sformatf("hold%0d_imm", k), r0_imm, 32'h5);
      chk($sformatf("hold%0d_rd", k), {27'b0, r0_rd}, 32'd1);
    end
    flush_in = 1'b1;
    pre_ready("flush_ready", 1'b1);
    tick();
    chk("flush_valid", {31'b0, r0_valid}, 32'h0);
    chk("flush_pc_hold", r0_pc, 32'h200);
    flush_in = 1'b0;

    // Load stuck in EX: ID waits without counting; one bubble once EX drains.
    ex_ready = 1'b1;
    drive(1'b1, I_LW_X5, 32'h300, 1'b0, 5'd0, 32'h0);
    tick();
    chk("exst_lw_rd", {27'b0, r0_rd}, 32'd5);
    ex_ready = 1'b0;
    drive(1'b1, I_ADD_X6_X5X5, 32'h304, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      pre_ready($sformatf("exst%0d_ready", k), 1'b0);
      tick();
      chk($sformatf("exst%0d_valid", k), {31'b0, r0_valid}, 32'h1);
      chk($sformatf("exst%0d_pc", k), r0_pc, 32'h300);
      chk($sformatf("exst%0d_cnt", k), {16'b0, r0_cnt}, 32'd2);
    end
    ex_ready = 1'b1;
    pre_ready("exst_bub_ready", 1'b0);
    tick();
    chk("exst_bub_valid", {31'b0, r0_valid}, 32'h0);
    chk("exst_bub_cnt", {16'b0, r0_cnt}, 32'd3);
    pre_ready("exst_go_ready", 1'b1);
    tick();
    chk("exst_go_valid", {31'b0, r0_valid}, 32'h1);
    chk("exst_go_pc", r0_pc, 32'h304);
    chk("exst_go_rd", {27'b0, r0_rd}, 32'd6);

    // Flush overrides a pending load-use hazard and is not counted as a stall.
    drive(1'b1, I_LW_X5, 32'h308, 1'b0, 5'd0, 32'h0);
    tick();
    drive(1'b1, I_ADD_X6_X5X5, 32'h30C, 1'b0, 5'd0, 32'h0);
    flush_in = 1'b1;
    pre_ready("flhz_ready", 1'b1);
    tick();
    chk("flhz_valid", {31'b0, r0_valid}, 32'h0);
    chk("flhz_cnt", {16'b0, r0_cnt}, 32'd3);
    flush_in = 1'b0;

    // Asynchronous reset in the middle of a hazard stall.
    drive(1'b1, I_LW_X5, 32'h310, 1'b0, 5'd0, 32'h0);
    tick();
    drive(1'b1, I_ADD_X6_X5X5, 32'h314, 1'b0, 5'd0, 32'h0);
    pre_ready("arst_pre_ready", 1'b0);
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, r0_valid}, 32'h0);
    chk("arst_cnt", {16'b0, r0_cnt}, 32'h0);
    chk("arst_rd", {27'b0, r0_rd}, 32'h0);
    chk("arst_pc", r0_pc, 32'h0);
    tick();
    arst_n = 1'b1;
    drive(1'b1, I_ADD_X3_X2, 32'h400, 1'b0, 5'd0, 32'h0);
    tick();
    chk("arst_rf0_a", r0_a, 32'h0);
    chk("arst_rf1_a", r1_a, 32'h0);
    chk("arst_after_valid", {31'b0, r0_valid}, 32'h1);

    // RV32E: x20 write must not alias onto x4.
    drive(1'b0, 32'h0, 32'h404, 1'b1, 5'd4, 32'h44);
    tick();
    drive(1'b0, 32'h0, 32'h408, 1'b1, 5'd20, 32'h99);
    tick();
    drive(1'b1, I_ADD_X3_X4, 32'h40C, 1'b0, 5'd0, 32'h0);
    tick();
    chk("e_x20_alias_a", r1_a, 32'h44);
    chk("e_x3_ill", {31'b0, r1_ill}, 32'h0);

    drive(1'b1, I_ADD_X17, 32'h410, 1'b0, 5'd0, 32'h0);
    tick();
    chk("e_x17_valid", {31'b0, r1_valid}, 32'h1);
    chk("e_x17_ill", {31'b0, r1_ill}, 32'h1);
    chk("e_x17_rf_en", {31'b0, r1_ctrl.rf_en}, 32'h0);
    chk("i_x17_ill", {31'b0, r0_ill}, 32'h0);
    chk("i_x17_rf_en", {31'b0, r0_ctrl.rf_en}, 32'h1);

    // 2-bit stall counter saturates at 3.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, I_LW_X5, 32'h500, 1'b0, 5'd0, 32'h0);
      tick();
      drive(1'b1, I_ADD_X6_X5X5, 32'h504, 1'b0, 5'd0, 32'h0);
      #1;
      chk($sformatf("sat%0d_ready", k), {31'b0, r1_ready}, 32'h0);
      tick();
      chk($sformatf("sat%0d_cnt", k), {30'b0, r1_cnt}, (k < 3) ? 32'(k) : 32'd3);
      tick();
    end
    chk("sat_wide_cnt", {16'b0, r0_cnt}, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
